semaforo_temporizado: RTL and testbench

//  Traffic-light controller: green/yellow/red Moore FSM with on-chip dwell timers. Successor to
//  the fixed 3-state controller; the external TIMEOUT input is replaced by internal counters.

---
 rtl/semaforo_pkg.sv | 28 ++
 rtl/semaforo_timer.sv | 30 +++
 rtl/semaforo_temporizado.sv | 148 ++++++++++++++
 tb/tb_semaforo_temporizado.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/semaforo_pkg.sv
// Shared state codes, state type and lamp encodings for the timed traffic-light controller.
// Lamp vectors are ordered {GRN, YLW, RED}.
package semaforo_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_GRN = 2'b00;
  localparam state_t S_YLW = 2'b01;
  localparam state_t S_RED = 2'b10;
  localparam state_t S_ILL = 2'b11;

  localparam logic [2:0] LAMP_GRN = 3'b100;
  localparam logic [2:0] LAMP_YLW = 3'b010;
  localparam logic [2:0] LAMP_RED = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  function automatic logic [2:0] lamp_decode(input state_t st);
    logic [2:0] lamps;
    case (st)
      S_GRN:   lamps = LAMP_GRN;
      S_YLW:   lamps = LAMP_YLW;
      S_RED:   lamps = LAMP_RED;
      default: lamps = LAMP_OFF;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/semaforo_timer.sv
// Loadable dwell down-counter: holds at zero, reports expired while the count is zero.
module semaforo_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = {CNT_W{1'b0}}
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_r;

  // Dwell counter: load on state entry, otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {CNT_W{1'b0}}) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/semaforo_temporizado.sv
// Timed green/yellow/red Moore controller with latched car request and minimum green time.
// Define SEMAFORO_PED_EN to add the pedestrian button (PED) and walk lamp (WALK).
module semaforo_temporizado
  import semaforo_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int T_GRN_MIN = 4,
  parameter int T_YLW     = 2,
  parameter int T_RED     = 8
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       CAR,
`ifdef SEMAFORO_PED_EN
  input  logic       PED,
  output logic       WALK,
`endif
  output logic       GRN,
  output logic       YLW,
  output logic       RED,
  output logic [1:0] state_o
);

  if (T_GRN_MIN < 1 || T_GRN_MIN > (2**CNT_W - 1)) begin : g_bad_t_grn
    $error("semaforo_temporizado: T_GRN_MIN out of range");
  end
  if (T_YLW < 1 || T_YLW > (2**CNT_W - 1)) begin : g_bad_t_ylw
    $error("semaforo_temporizado: T_YLW out of range");
  end
  if (T_RED < 1 || T_RED > (2**CNT_W - 1)) begin : g_bad_t_red
    $error("semaforo_temporizado: T_RED out of range");
  end

  localparam logic [CNT_W-1:0] LD_GRN = CNT_W'(T_GRN_MIN - 1);
  localparam logic [CNT_W-1:0] LD_YLW = CNT_W'(T_YLW - 1);
  localparam logic [CNT_W-1:0] LD_RED = CNT_W'(T_RED - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic             expired_s;
  logic             load_s;
  logic [CNT_W-1:0] load_val_s;
  logic             car_pend_r;
  logic             exit_req_s;
  logic             grn_exit_s;
  logic [2:0]       lamps_s;
`ifdef SEMAFORO_PED_EN
  logic             ped_pend_r;
  logic             walk_grant_r;
  logic             red_exit_s;
`endif

  semaforo_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_GRN)
  ) u_timer (
    .clk      (clk),
    .res_n    (res_n),
    .load     (load_s),
    .load_val (load_val_s),
    .expired  (expired_s)
  );

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_r <= S_GRN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic plus the dwell reload for whichever state is entered next.
  always_comb begin
`ifdef SEMAFORO_PED_EN
    exit_req_s = car_pend_r | CAR | ped_pend_r | PED;
`else
    exit_req_s = car_pend_r | CAR;
`endif
    next_state_s = state_r;
    case (state_r)
      S_GRN: begin
        if (expired_s && exit_req_s) next_state_s = S_YLW;
        else                         next_state_s = S_GRN;
      end
      S_YLW: begin
        if (expired_s) next_state_s = S_RED;
        else           next_state_s = S_YLW;
      end
      S_RED: begin
        if (expired_s) next_state_s = S_GRN;
        else           next_state_s = S_RED;
      end
      default: next_state_s = S_GRN;
    endcase

    load_s     = (next_state_s != state_r);
    grn_exit_s = (state_r == S_GRN) && (next_state_s == S_YLW);
    case (next_state_s)
      S_YLW:   load_val_s = LD_YLW;
      S_RED:   load_val_s = LD_RED;
      default: load_val_s = LD_GRN;
    endcase
  end

  // Car request latch; the green exit clears it even if CAR is still high.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      car_pend_r <= 1'b0;
    end else if (grn_exit_s) begin
      car_pend_r <= 1'b0;
    end else if ((state_r == S_GRN) && CAR) begin
      car_pend_r <= 1'b1;
    end else begin
      car_pend_r <= car_pend_r;
    end
  end

`ifdef SEMAFORO_PED_EN
  assign red_exit_s = (state_r == S_RED) && (next_state_s == S_GRN);

  // Pedestrian latch and walk grant; the grant is decided when green ends and held through red.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      ped_pend_r   <= 1'b0;
      walk_grant_r <= 1'b0;
    end else if (grn_exit_s) begin
      ped_pend_r   <= 1'b0;
      walk_grant_r <= ped_pend_r | PED;
    end else begin
      ped_pend_r   <= ped_pend_r | PED;
      if (red_exit_s) walk_grant_r <= 1'b0;
      else            walk_grant_r <= walk_grant_r;
    end
  end
`endif

  // Lamp decode straight from the state register.
  always_comb begin
    lamps_s         = lamp_decode(state_r);
    {GRN, YLW, RED} = lamps_s;
    state_o         = state_r;
`ifdef SEMAFORO_PED_EN
    WALK            = (state_r == S_RED) && walk_grant_r;
`endif
  end

endmodule

// File: tb/tb_semaforo_temporizado.sv
// Scoreboard bench for semaforo_temporizado: a phase/elapsed-time model predicts lamps each cycle.
// Honours SEMAFORO_PED_EN when defined.
module tb_semaforo_temporizado;

  localparam int T_GRN_MIN = 4;
  localparam int T_YLW     = 2;
  localparam int T_RED     = 8;
`ifdef SEMAFORO_PED_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       res_n = 1'b0;
  logic       CAR   = 1'b0;
  logic       GRN, YLW, RED;
  logic [1:0] state_o;
  logic       walk_s;
`ifdef SEMAFORO_PED_EN
  logic       PED = 1'b0;
  logic       WALK;
  assign walk_s = WALK;
`else
  assign walk_s = 1'b0;
`endif

  semaforo_temporizado #(
    .CNT_W     (8),
    .T_GRN_MIN (T_GRN_MIN),
    .T_YLW     (T_YLW),
    .T_RED     (T_RED)
  ) dut (
    .clk     (clk),
    .res_n   (res_n),
    .CAR     (CAR),
`ifdef SEMAFORO_PED_EN
    .PED     (PED),
    .WALK    (WALK),
`endif
    .GRN     (GRN),
    .YLW     (YLW),
    .RED     (RED),
    .state_o (state_o)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0/1/2 = green/yellow/red, m_t = cycles already spent in the phase.
  int m_ph, m_t;
  bit m_car, m_ped, m_walk;
  logic [5:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic int dur_of(input int ph);
    if (ph == 0)      return T_GRN_MIN;
    else if (ph == 1) return T_YLW;
    else              return T_RED;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_car = 1'b0; m_ped = 1'b0; m_walk = 1'b0;
  endtask

  function automatic logic [5:0] model_out();
    logic [1:0] code;
    code = m_ph[1:0];
    return {(m_ph == 0), (m_ph == 1), (m_ph == 2), code, ((m_ph == 2) && m_walk)};
  endfunction

  task automatic model_step(input bit car, input bit ped);
    bit last;
    last = (m_t + 1 >= dur_of(m_ph));
    if (m_ph == 0) begin
      if (last && (m_car || car || m_ped || ped)) begin
        m_walk = m_ped || ped;
        m_car = 1'b0; m_ped = 1'b0; m_ph = 1; m_t = 0;
      end else begin
        m_car = m_car || car; m_ped = m_ped || ped; m_t++;
      end
    end else begin
      m_ped = m_ped || ped;
      if (last) begin
        if (m_ph == 2) m_walk = 1'b0;
        m_ph = (m_ph == 1) ? 2 : 0;
        m_t  = 0;
      end else begin
        m_t++;
      end
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, record expectation, advance the model.
  task automatic apply(input bit rn, input bit car, input bit ped);
    bit ped_eff;
    ped_eff = PED_EN && ped;
    @(negedge clk);
    res_n = rn;
    CAR   = car;
`ifdef SEMAFORO_PED_EN
    PED   = ped_eff;
`endif
    if (!rn) model_reset();
    exp_q.push_back(model_out());
    if (rn) model_step(car, ped_eff);
  endtask

  // Monitor: shortly after each falling edge, compare DUT outputs with queued expectations.
  initial begin
    logic [5:0] exp_v, act_v;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        act_v = {GRN, YLW, RED, state_o, walk_s};
        n_vec++;
        if (act_v !== exp_v)
          begin
            n_err++;
            $display("FAIL vec%0d lamps(GRN YLW RED state WALK) t=%0t: got %b expected %b",
                     n_vec, $time, act_v, exp_v);
          end
      end
    end
  end

  task automatic wait_red_cycle(input int k);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_ph == 2 && m_t == k) begin
        hit = 1'b1;
        break;
      end
      apply(1'b1, 1'b0, 1'b0);
    end
    if (!hit) begin
      n_vec++; n_err++;
      $display("FAIL wait_red: got no red cycle %0d within 40 cycles, required one", k + 1);
    end
  endtask

  initial begin
    model_reset();
    // Reset held with CAR high.
    repeat (3) apply(1'b0, 1'b1, 1'b0);
    // CAR pulse right after reset, then a long idle green.
    apply(1'b1, 1'b1, 1'b0);
    repeat (70) apply(1'b1, 1'b0, 1'b0);
    // Long idle, then a single pulse with minimum green already served.
    repeat (20) apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    // CAR only during yellow/red, then idle green.
    repeat (12) apply(1'b1, (m_ph != 0), 1'b0);
    repeat (20) apply(1'b1, 1'b0, 1'b0);
    // Reset asserted in the third red cycle, then a car waiting through the minimum green.
    apply(1'b1, 1'b1, 1'b0);
    wait_red_cycle(2);
    apply(1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    repeat (20) apply(1'b1, 1'b0, 1'b0);
    // Pedestrian button pressed during red only.
    apply(1'b1, 1'b1, 1'b0);
    wait_red_cycle(1);
    apply(1'b1, 1'b0, 1'b1);
    repeat (40) apply(1'b1, 1'b0, 1'b0);
    // Randomised traffic with occasional resets.
    repeat (600)
      apply(($urandom_range(99) != 0), ($urandom_range(9) == 0), ($urandom_range(14) == 0));
    apply(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked expectations, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
